// File: rtl/axis_flit_injector_if.sv
// Bundles the AXI-Stream beat input and the credit-based flit output of the NoC injection shim.
// The master side drives beats and returns credits; the slave side is the injector.
interface axis_flit_injector_if #(
    parameter int TDATA_WIDTH          = 128,
    parameter int DEST_WIDTH           = 4,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int FLIT_BUFFER_DEPTH    = 4
);
    localparam int FLIT_WIDTH   = TDATA_WIDTH / SERIALIZATION_FACTOR;
    localparam int CREDIT_WIDTH = $clog2(FLIT_BUFFER_DEPTH + 1);

    logic                    axis_tvalid;
    logic                    axis_tready;
    logic [TDATA_WIDTH-1:0]  axis_tdata;
    logic                    axis_tlast;
    logic [DEST_WIDTH-1:0]   axis_tdest;
    logic [FLIT_WIDTH-1:0]   data_out;
    logic [DEST_WIDTH-1:0]   dest_out;
    logic                    is_tail_out;
    logic                    send_out;
    logic                    credit_in;
    logic [CREDIT_WIDTH-1:0] credits_avail;
    logic                    credit_err;

    modport master (
        output axis_tvalid, axis_tdata, axis_tlast, axis_tdest, credit_in,
        input  axis_tready, data_out, dest_out, is_tail_out, send_out, credits_avail, credit_err
    );

    modport slave (
        input  axis_tvalid, axis_tdata, axis_tlast, axis_tdest, credit_in,
        output axis_tready, data_out, dest_out, is_tail_out, send_out, credits_avail, credit_err
    );
endinterface

// File: rtl/axis_flit_injector.sv
// AXI-Stream to NoC flit injector: buffers whole beats, slices each into flits LSB-first,
// and issues one flit per cycle while the downstream flit buffer has credits.
module axis_flit_injector #(
    parameter int TDATA_WIDTH          = 128,
    parameter int DEST_WIDTH           = 4,
    parameter int SERIALIZATION_FACTOR = 4,
    parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
    parameter int FLIT_BUFFER_DEPTH    = 4,
    parameter int BUFFER_DEPTH         = 2,
    parameter int CREDIT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                 clk_noc,
    input  logic                 rst_noc_sync,
    axis_flit_injector_if.slave  bus
);
    localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam int IDX_W = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;

    localparam logic [PTR_W-1:0]        PTR_LAST    = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0]        CNT_FULL    = CNT_W'(BUFFER_DEPTH);
    localparam logic [IDX_W-1:0]        IDX_LAST    = IDX_W'(SERIALIZATION_FACTOR - 1);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_INIT = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);

    logic [TDATA_WIDTH-1:0] data_mem [BUFFER_DEPTH];
    logic [DEST_WIDTH-1:0]  dest_mem [BUFFER_DEPTH];
    logic                   last_mem [BUFFER_DEPTH];

    logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]        count_reg, count_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [CREDIT_WIDTH-1:0] credits_reg, credits_next;
    logic                    credit_err_reg, credit_err_next;
    logic                    send_reg, send_next;
    logic                    tail_reg, tail_next;
    logic [FLIT_WIDTH-1:0]   data_reg, data_next;
    logic [DEST_WIDTH-1:0]   dest_reg, dest_next;

    logic                   tready;
    logic                   push;
    logic                   issue;
    logic                   last_flit;
    logic                   pop;
    logic [TDATA_WIDTH-1:0] head_data;
    logic [FLIT_WIDTH-1:0]  flit_slices [SERIALIZATION_FACTOR];
    logic [FLIT_WIDTH-1:0]  cur_flit;

    // Ready looks only at the registered occupancy, so a pop never frees a slot in the same cycle.
    assign tready    = !rst_noc_sync && (count_reg < CNT_FULL);
    assign push      = bus.axis_tvalid && tready;
    assign issue     = (count_reg != '0) && (credits_reg != '0);
    assign last_flit = (idx_reg == IDX_LAST);
    assign pop       = issue && last_flit;
    assign head_data = data_mem[rd_ptr_reg];

    for (genvar gi = 0; gi < SERIALIZATION_FACTOR; gi++) begin : g_slice
        assign flit_slices[gi] = head_data[gi*FLIT_WIDTH +: FLIT_WIDTH];
    end

    if (SERIALIZATION_FACTOR == 1) begin : g_sel_single
        assign cur_flit = flit_slices[0];
    end else begin : g_sel_multi
        assign cur_flit = flit_slices[idx_reg];
    end

    always_comb begin
        wr_ptr_next     = wr_ptr_reg;
        rd_ptr_next     = rd_ptr_reg;
        count_next      = count_reg;
        idx_next        = idx_reg;
        credits_next    = credits_reg;
        credit_err_next = credit_err_reg;
        send_next       = 1'b0;
        tail_next       = tail_reg;
        data_next       = data_reg;
        dest_next       = dest_reg;

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase

        if (issue) begin
            idx_next  = last_flit ? '0 : idx_reg + IDX_W'(1);
            send_next = 1'b1;
            data_next = cur_flit;
            dest_next = dest_mem[rd_ptr_reg];
            tail_next = last_mem[rd_ptr_reg] && last_flit;
        end

        // A returned credit that would exceed the buffer depth is dropped and flagged.
        case ({issue, bus.credit_in})
            2'b10: credits_next = credits_reg - CREDIT_WIDTH'(1);
            2'b01: begin
                if (credits_reg == CREDIT_INIT) begin
                    credit_err_next = 1'b1;
                end else begin
                    credits_next = credits_reg + CREDIT_WIDTH'(1);
                end
            end
            default: credits_next = credits_reg;
        endcase
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            idx_reg        <= '0;
            credits_reg    <= CREDIT_INIT;
            credit_err_reg <= 1'b0;
            send_reg       <= 1'b0;
            tail_reg       <= 1'b0;
            data_reg       <= '0;
            dest_reg       <= '0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            idx_reg        <= idx_next;
            credits_reg    <= credits_next;
            credit_err_reg <= credit_err_next;
            send_reg       <= send_next;
            tail_reg       <= tail_next;
            data_reg       <= data_next;
            dest_reg       <= dest_next;
        end
    end

    always_ff @(posedge clk_noc) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= bus.axis_tdata;
            dest_mem[wr_ptr_reg] <= bus.axis_tdest;
            last_mem[wr_ptr_reg] <= bus.axis_tlast;
        end
    end

    assign bus.axis_tready   = tready;
    assign bus.data_out      = data_reg;
    assign bus.dest_out      = dest_reg;
    assign bus.is_tail_out   = tail_reg;
    assign bus.send_out      = send_reg;
    assign bus.credits_avail = credits_reg;
    assign bus.credit_err    = credit_err_reg;
endmodule

// File: tb/tb_axis_flit_injector.sv
// Bench for axis_flit_injector: lane 0 serializes 128-bit beats into four flits, lane 1 passes
// 32-bit beats as single flits; a transaction-level model predicts every output cycle by cycle.
module tb_axis_flit_injector;
    localparam int FBD = 4;
    localparam int BD  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axis_flit_injector_if #(.TDATA_WIDTH(128), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(4),
                            .FLIT_BUFFER_DEPTH(FBD)) bus0 ();
    axis_flit_injector_if #(.TDATA_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(1),
                            .FLIT_BUFFER_DEPTH(FBD)) bus1 ();

    axis_flit_injector #(.TDATA_WIDTH(128), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(4),
                         .FLIT_BUFFER_DEPTH(FBD), .BUFFER_DEPTH(BD)) dut0 (
        .clk_noc(clk), .rst_noc_sync(rst), .bus(bus0));
    axis_flit_injector #(.TDATA_WIDTH(32), .DEST_WIDTH(4), .SERIALIZATION_FACTOR(1),
                         .FLIT_BUFFER_DEPTH(FBD), .BUFFER_DEPTH(BD)) dut1 (
        .clk_noc(clk), .rst_noc_sync(rst), .bus(bus1));

    // Stimulus side
    logic         tvalid [2];
    logic [127:0] tdata  [2];
    logic         tlast  [2];
    logic [3:0]   tdest  [2];
    logic         cin    [2];

    assign bus0.axis_tvalid = tvalid[0];
    assign bus0.axis_tdata  = tdata[0];
    assign bus0.axis_tlast  = tlast[0];
    assign bus0.axis_tdest  = tdest[0];
    assign bus0.credit_in   = cin[0];
    assign bus1.axis_tvalid = tvalid[1];
    assign bus1.axis_tdata  = tdata[1][31:0];
    assign bus1.axis_tlast  = tlast[1];
    assign bus1.axis_tdest  = tdest[1];
    assign bus1.credit_in   = cin[1];

    // Observed side
    logic        send_o   [2];
    logic [31:0] data_o   [2];
    logic [3:0]  dest_o   [2];
    logic        tail_o   [2];
    logic        tready_o [2];
    logic [2:0]  cred_o   [2];
    logic        err_o    [2];

    assign send_o[0]   = bus0.send_out;
    assign data_o[0]   = bus0.data_out;
    assign dest_o[0]   = bus0.dest_out;
    assign tail_o[0]   = bus0.is_tail_out;
    assign tready_o[0] = bus0.axis_tready;
    assign cred_o[0]   = bus0.credits_avail;
    assign err_o[0]    = bus0.credit_err;
    assign send_o[1]   = bus1.send_out;
    assign data_o[1]   = bus1.data_out;
    assign dest_o[1]   = bus1.dest_out;
    assign tail_o[1]   = bus1.is_tail_out;
    assign tready_o[1] = bus1.axis_tready;
    assign cred_o[1]   = bus1.credits_avail;
    assign err_o[1]    = bus1.credit_err;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  dest;
        logic        tail;
    } flit_t;

    // Reference model: queue of flits still owed by each lane plus the credit balance.
    flit_t exp_q [2][$];
    int    pend_prev [2];
    int    cred_m    [2];
    logic  err_m     [2];
    logic  cin_prev  [2];
    bit    model_on = 1'b0;
    int    checks = 0;
    int    errors = 0;
    bit    end_req = 1'b0;
    bit    end_done = 1'b0;
    int    to_cnt = 0;

    // Driver bookkeeping
    int   owed   [2];
    bit   ret_en [2];
    logic acc    [2];
    logic saw_send [2];

    function automatic int lane_sf(int l);
        return (l == 0) ? 4 : 1;
    endfunction

    task automatic chk(string name, int l, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got 0x%0h expected 0x%0h", name, l, got, exp);
        end
    endtask

    always @(negedge clk) begin
        int    sf;
        int    beats;
        int    c;
        logic  exp_send;
        logic  exp_ready;
        flit_t f;
        for (int l = 0; l < 2; l++) begin
            sf = lane_sf(l);
            if (rst) begin
                chk("tready_in_reset", l, 32'(tready_o[l]), 32'd0);
                exp_q[l].delete();
                pend_prev[l] = 0;
                cred_m[l]    = FBD;
                err_m[l]     = 1'b0;
                cin_prev[l]  = 1'b0;
                model_on     = 1'b1;
            end else if (model_on) begin
                // A flit may leave only if one was waiting and a credit existed last cycle.
                exp_send = (pend_prev[l] > 0) && (cred_m[l] > 0);
                chk("send_out", l, 32'(send_o[l]), 32'(exp_send));
                if (send_o[l] && exp_q[l].size() > 0) begin
                    f = exp_q[l].pop_front();
                    $display("lane%0d flit data=%08h dest=%0h tail=%0d", l, data_o[l], dest_o[l], tail_o[l]);
                    chk("data_out", l, data_o[l], f.data);
                    chk("dest_out", l, 32'(dest_o[l]), 32'(f.dest));
                    chk("is_tail_out", l, 32'(tail_o[l]), 32'(f.tail));
                end
                c = cred_m[l] - int'(exp_send) + int'(cin_prev[l]);
                if (c > FBD) begin
                    c = FBD;
                    err_m[l] = 1'b1;
                end
                chk("credits_avail", l, 32'(cred_o[l]), 32'(c));
                chk("credit_err", l, 32'(err_o[l]), 32'(err_m[l]));
                beats = (exp_q[l].size() + sf - 1) / sf;
                exp_ready = (beats < BD);
                chk("axis_tready", l, 32'(tready_o[l]), 32'(exp_ready));
                pend_prev[l] = exp_q[l].size();
                cred_m[l]    = c;
                if (tvalid[l] && exp_ready) begin
                    for (int i = 0; i < sf; i++) begin
                        f.data = tdata[l][i*32 +: 32];
                        f.dest = tdest[l];
                        f.tail = tlast[l] && (i == sf - 1);
                        exp_q[l].push_back(f);
                    end
                end
                cin_prev[l] = cin[l];
            end
        end
        if (end_req && !end_done) begin
            for (int l = 0; l < 2; l++) begin
                chk("queue_drained", l, 32'(exp_q[l].size()), 32'd0);
            end
            chk("handshake_timeouts", 0, 32'(to_cnt), 32'd0);
            end_done = 1'b1;
        end
    end

    task automatic step();
        @(negedge clk);
        for (int l = 0; l < 2; l++) begin
            if (rst) owed[l] = 0;
            else if (send_o[l]) owed[l]++;
            saw_send[l] = send_o[l];
            acc[l] = tvalid[l] && tready_o[l];
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            if (acc[l]) tvalid[l] = 1'b0;
            if (ret_en[l] && owed[l] > 0 && $urandom_range(0, 2) != 0) begin
                cin[l] = 1'b1;
                owed[l]--;
            end else begin
                cin[l] = 1'b0;
            end
        end
    endtask

    task automatic put_beat(int l, logic [127:0] d, logic [3:0] dst, logic lst);
        tvalid[l] = 1'b1;
        tdata[l]  = d;
        tdest[l]  = dst;
        tlast[l]  = lst;
        for (int n = 0; n < 200; n++) begin
            step();
            if (acc[l]) return;
        end
        to_cnt++;
        tvalid[l] = 1'b0;
    endtask

    task automatic rand_beat(int l);
        tvalid[l] = 1'b1;
        tdata[l]  = {$urandom, $urandom, $urandom, $urandom};
        tdest[l]  = 4'($urandom_range(0, 15));
        tlast[l]  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 300; n++) begin
            step();
            if (owed[0] == 0 && owed[1] == 0 && !tvalid[0] && !tvalid[1] &&
                exp_q[0].size() == 0 && exp_q[1].size() == 0) return;
        end
        to_cnt++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int l = 0; l < 2; l++) begin
            tvalid[l] = 1'b0; tdata[l] = '0; tlast[l] = 1'b0; tdest[l] = '0;
            cin[l] = 1'b0; owed[l] = 0; ret_en[l] = 1'b1; acc[l] = 1'b0; saw_send[l] = 1'b0;
        end
        do_reset();
        repeat (2) step();

        // Single four-flit beat with known payload and routing.
        put_beat(0, 128'h33333333_22222222_11111111_00000000, 4'h5, 1'b1);
        repeat (10) step();

        // Back-to-back single-flit beats, tail only on the last.
        put_beat(1, 128'hA1A1A1A1, 4'h2, 1'b0);
        put_beat(1, 128'hB2B2B2B2, 4'h2, 1'b0);
        put_beat(1, 128'hC3C3C3C3, 4'h2, 1'b1);
        wait_idle();

        // Credit starvation, a single returned credit, and a full beat buffer.
        ret_en[0] = 1'b0;
        put_beat(0, 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3, 4'h3, 1'b0);
        put_beat(0, 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3, 4'h3, 1'b1);
        repeat (12) step();
        cin[0] = 1'b1;
        owed[0]--;
        repeat (6) step();
        put_beat(0, 128'hF0F0F0F0_F1F1F1F1_F2F2F2F2_F3F3F3F3, 4'h7, 1'b0);
        tvalid[0] = 1'b1;
        tdata[0]  = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
        tdest[0]  = 4'h8;
        tlast[0]  = 1'b1;
        repeat (6) step();
        ret_en[0] = 1'b1;
        wait_idle();

        // Credit returned while already full: saturate and latch the error.
        cin[0] = 1'b1;
        cin[1] = 1'b1;
        repeat (6) step();

        // Reset in the middle of a packet discards the rest of it.
        put_beat(0, {$urandom, $urandom, $urandom, $urandom}, 4'h9, 1'b1);
        for (int n = 0; n < 50; n++) begin
            step();
            if (saw_send[0]) break;
        end
        do_reset();
        repeat (12) step();

        // Randomized traffic with bursts of withheld credits.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            step();
            if (cyc % 64 == 0) ret_en[$urandom_range(0, 1)] = ($urandom_range(0, 3) != 0);
            for (int l = 0; l < 2; l++) begin
                if (!tvalid[l] && $urandom_range(0, 1) == 1) rand_beat(l);
            end
        end
        ret_en[0] = 1'b1;
        ret_en[1] = 1'b1;
        wait_idle();
        repeat (4) step();

        end_req = 1'b1;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_flit_injector.md
Name: axis_flit_injector

Overview:
Single-clock AXI-Stream-to-flit injection shim for the NoC router local port. It buffers whole AXIS beats, serializes each beat into SERIALIZATION_FACTOR flits, and issues them under credit-based flow control against the router's input flit buffer. It adds a registered credit counter, credit-overflow detection and a runtime credit-availability status output.

Parameters:
TDATA_WIDTH, 128, AXIS beat width in bits; must be divisible by SERIALIZATION_FACTOR
DEST_WIDTH, 4, width of the concatenated {tid, tdest} routing field
SERIALIZATION_FACTOR, 4, number of flits per beat; 1 is legal
FLIT_WIDTH, TDATA_WIDTH/SERIALIZATION_FACTOR, flit payload width
FLIT_BUFFER_DEPTH, 4, downstream flit buffer depth; initial credit count
BUFFER_DEPTH, 2, input beat FIFO depth (>=1)
CREDIT_WIDTH, $clog2(FLIT_BUFFER_DEPTH+1), credit counter width

Ports:
clk_noc  in  1  NoC clock; all logic is on its rising edge
rst_noc_sync  in  1  synchronous active-high reset
axis_tvalid  in  1  beat valid
axis_tready  out  1  beat ready
axis_tdata  in  TDATA_WIDTH  beat payload
axis_tlast  in  1  last beat of the packet
axis_tdest  in  DEST_WIDTH  {tid, tdest} routing field
data_out  out  FLIT_WIDTH  flit payload
dest_out  out  DEST_WIDTH  flit destination
is_tail_out  out  1  tail flit marker
send_out  out  1  flit valid, one cycle per flit
credit_in  in  1  one credit returned per high cycle
credits_avail  out  CREDIT_WIDTH  current credit count
credit_err  out  1  sticky credit-overflow flag

Behaviour:
- Reset (clk_noc edge with rst_noc_sync=1):
  - Beat FIFO is emptied and the flit index is cleared to 0.
  - Credits are set to FLIT_BUFFER_DEPTH.
  - send_out, is_tail_out, data_out, dest_out and credit_err are set to 0.
  - axis_tready is 0 while reset is asserted and is 1 in the first cycle after deassertion.
  - Reset during a packet discards all buffered beats and partial serialization. Nothing further is emitted for those beats.
- Input handshake:
  - axis_tready = (fifo_count < BUFFER_DEPTH), derived from registered state only. It never depends on axis_tvalid or on a same-cycle pop, so there is no full pass-through.
  - A beat is accepted when axis_tvalid && axis_tready. tdata, tlast and tdest are stored together.
- Serialization:
  - The head beat is split into flits. Flit i = tdata[i*FLIT_WIDTH +: FLIT_WIDTH], index 0 (LSBs) first.
  - dest_out carries the beat's tdest on every flit.
  - is_tail_out=1 only on flit SERIALIZATION_FACTOR-1 of a beat with tlast=1.
  - The beat is popped when its last flit is issued.
- Issue rule:
  - In cycle C a flit is issued iff the FIFO is non-empty and credits>0.
  - The output registers load at the end of C, so send_out=1 with the flit in cycle C+1.
  - While credits remain and beats are available, flits go out one per cycle back-to-back, including across beat boundaries.
  - When send_out=0, data_out, dest_out and is_tail_out hold their previous values; consumers qualify them with send_out.
- Latency: a beat accepted in cycle N, into an empty FIFO with credits available, produces flit 0 on send_out in cycle N+2.
- Credits:
  - Counter updates each cycle: send only gives -1; credit_in only gives +1; both give no change.
  - credit_in affects issue decisions from the next cycle only; there is no combinational credit_in-to-send_out path.
  - credit_in=1 with the counter at FLIT_BUFFER_DEPTH and no issue: the counter saturates and credit_err is set. credit_err stays set until reset.
  - credits_avail is the registered counter value.
- Arithmetic: the flit index counts 0..SERIALIZATION_FACTOR-1 and wraps to 0 on pop. The FIFO pointers wrap modulo BUFFER_DEPTH.

Test Plan:
1. Reset mid-packet (SF=4, 1 of 4 flits sent, reset pulsed) -> no further send_out; credits_avail=4; credit_err=0; tready=0 during reset and 1 one cycle after.
2. SF=4, one beat with tdata=0x33333333_22222222_11111111_00000000, tdest=0x5, tlast=1, accepted in cycle N -> send_out high in cycles N+2..N+5 with data 0x0, 0x11111111, 0x22222222, 0x33333333; dest_out=0x5 on all four; is_tail_out only in N+5.
3. FLIT_BUFFER_DEPTH=4, two beats (8 flits), no credit_in -> exactly 4 flits, then credits_avail=0 and stall; single credit_in pulse in cycle C -> exactly one flit with send_out in cycle C+2.
4. Credit returned in the same cycle as an issue -> credits_avail unchanged.
5. BUFFER_DEPTH=2 with credits_avail=0 -> two beats accepted, then axis_tready=0; a third beat with tvalid held is not accepted until a beat pops.
6. credit_in pulsed while credits_avail=4 and idle -> credits_avail stays 4; credit_err=1 and stays 1 until reset.
7. SF=1, three back-to-back beats, last with tlast=1 -> three consecutive send_out cycles; is_tail_out only on the third.
